mips_irq_ctrl: RTL and testbench
================================

Name: mips_irq_ctrl

Overview:
- Interrupt controller directly upstream of the MIPS core. Its o_coproc0_interrupt output drives the core's i_coproc0_interrupt_i.
- Collects NUM_IRQ external request lines and latches or samples them per source.
- Masks and prioritises the requests, then raises one registered interrupt line to coprocessor 0.
- Software controls it through a small word-addressed register window on the data-memory bus: pending, mask, edge-select, status/EOI.

Parameters:
NUM_IRQ, 8, number of request sources (1..16)
DATA_W, 32, bus data width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset, sampled on rising i_clk
i_irq  in  NUM_IRQ  raw interrupt request lines
i_irq_ack  in  1  one-cycle pulse: core has taken the exception
i_addr  in  2  register word index
i_we  in  1  register write strobe
i_re  in  1  register read strobe
i_wdata  in  DATA_W  write data
o_rdata  out  DATA_W  read data, combinational from the registers, valid while i_re=1
o_coproc0_interrupt  out  1  registered request to coprocessor 0
o_cause  out  4  index of the source being serviced

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous, active-low, on i_rst_n.
- Reset values: pending=0, mask=0, edge=0 (all sources level), state=IDLE, o_coproc0_interrupt=0, o_cause=0, edge-detect history=0.
- Register map by i_addr:
  - 0 PENDING: read. Write-1-clears edge bits only.
  - 1 MASK: read/write. 1 = enabled.
  - 2 EDGE: read/write. 1 = rising-edge source, 0 = level source.
  - 3 STATUS: read returns {state[1:0] at bits 9:8, any_req at bit 4, o_cause at bits 3:0}. Any write is EOI.
  - Unused upper bits read 0.
- Edge sources:
  - Rising edge (cur=1, prev=0) sets pending on the next clock.
  - Set and W1C on the same cycle: set wins.
- Level sources: the pending bit is the current sampled level; W1C has no effect.
- Request and priority:
  - req = pending & mask.
  - any_req = |req.
  - Winning index = lowest set bit of req.
- FSM states:
  - IDLE: if any_req, go to REQ. o_coproc0_interrupt <= 1 and o_cause <= winning index on the same clock.
  - REQ: hold the output high and keep o_cause frozen. On i_irq_ack go to SERVICE and drop o_coproc0_interrupt next clock. If any_req falls to 0 before the ack (masked or cleared), return to IDLE and drop the output.
  - SERVICE: output low, o_cause held. An EOI write returns to IDLE. Pending requests are re-evaluated the following cycle, so back-to-back interrupts need at least 1 idle cycle.
- Latency without sync: edge sampled at cycle N → pending at N+1 → o_coproc0_interrupt high at N+2.
- Corner cases:
  - i_irq_ack in IDLE or SERVICE: ignored.
  - EOI in IDLE or REQ: ignored.
  - i_we and i_re together: the read returns pre-write values.
  - Reset mid-REQ: the output falls on that clock and all state clears.

Optional Feature:
- Macro: MIPS_IRQ_SYNC_EN.
- Defined: i_irq passes through a two-flop synchroniser (reset 0) before edge detection and level sampling. Latency grows by 2 cycles (edge to output = 4).
- Undefined: i_irq is taken as already synchronous to i_clk and registered once.

Decomposition:
- Shared package mips_irq_pkg:
  - state encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2
  - register indices: REG_PENDING=0, REG_MASK=1, REG_EDGE=2, REG_STATUS=3
  - STATUS bit positions
- One sub-module, mips_irq_prio_enc: combinational lowest-index priority encoder (NUM_IRQ in; valid, 4-bit index out). The top holds the registers and FSM.

Test Plan:
- Reset then MASK=0x05, EDGE=0x01; rising edge on i_irq[0] → PENDING reads 0x01, o_coproc0_interrupt=1 two cycles after the edge (four with sync), o_cause=0.
- i_irq[2] level high and i_irq[0] edge in the same cycle with MASK=0x05 → o_cause=0. Ack, W1C 0x01, EOI → one idle cycle, then output high again with o_cause=2.
- In REQ, write MASK=0x00 before ack → o_coproc0_interrupt=0 next clock, STATUS state=IDLE.
- W1C of bit 0 in the same cycle as a new edge on i_irq[0] → PENDING bit 0 remains 1.
- i_irq_ack pulse in IDLE and EOI write in REQ → no state change, output unchanged.
- Assert i_rst_n=0 for one clock while in REQ with pending=0xFF → o_coproc0_interrupt=0 and all registers read 0 after that clock.

Source files
------------

// File: rtl/mips_irq_pkg.sv
// Shared definitions for the MIPS interrupt controller.
// Holds the FSM state encoding, the register window indices and the STATUS bit layout.
// No logic lives here; mips_irq_ctrl imports it.
package mips_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // STATUS read layout: {state[9:8], any_req[4], cause[3:0]}
    localparam int STAT_CAUSE_LSB = 0;
    localparam int STAT_CAUSE_W   = 4;
    localparam int STAT_ANY_BIT   = 4;
    localparam int STAT_STATE_LSB = 8;

endpackage

// File: rtl/mips_irq_prio_enc.sv
// Lowest-index priority encoder for the interrupt request vector.
// Purely combinational, zero latency; no backpressure (no handshake).
// Ports: req (NUM_IRQ) in; valid (any bit set) and idx (4-bit winning index) out.
module mips_irq_prio_enc #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [3:0]         idx
);

    always_comb begin
        valid = |req;
        idx   = 4'd0;
        // Scan downward so the lowest set bit is the last (and final) assignment.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/mips_irq_ctrl.sv
// Interrupt controller feeding the MIPS coprocessor-0 interrupt input.
// Latency: i_irq rising edge to o_coproc0_interrupt = 2 clocks (4 with MIPS_IRQ_SYNC_EN defined).
// Backpressure: none; the core acknowledges with i_irq_ack and software ends service with an EOI write.
// Ports: i_clk/i_rst_n (sync, active-low); i_irq request lines; i_irq_ack from the core;
//        i_addr/i_we/i_re/i_wdata/o_rdata register window; o_coproc0_interrupt and o_cause to the core.
// Optional macro MIPS_IRQ_SYNC_EN: adds a two-flop synchroniser on i_irq ahead of edge/level sampling.
module mips_irq_ctrl
    import mips_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int DATA_W  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_irq_ack,
    input  logic [1:0]         i_addr,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic [DATA_W-1:0]  o_rdata,
    output logic               o_coproc0_interrupt,
    output logic [3:0]         o_cause
);

    logic [NUM_IRQ-1:0] irq_cur;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_sel;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] req;
    logic               any_req;
    logic [3:0]         win_idx;
    logic               eoi;

    irq_state_t state, state_nxt;
    logic       intr_nxt;
    logic [3:0] cause_nxt;

    // Only the low NUM_IRQ data bits carry register content.
    logic unused_wdata;
    assign unused_wdata = ^i_wdata;

`ifdef MIPS_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_irq;
            sync2 <= sync1;
        end
    end

    assign irq_cur = sync2;
`else
    assign irq_cur = i_irq;
`endif

    assign rise = irq_cur & ~irq_prev;
    assign w1c  = (i_we && (i_addr == REG_PENDING)) ? i_wdata[NUM_IRQ-1:0] : '0;
    assign eoi  = i_we && (i_addr == REG_STATUS);

    // Edge bits: sticky, cleared by W1C, a new rise beats a same-cycle clear.
    // Level bits: simply track the sampled line.
    assign pending_nxt = (edge_sel & ((pending & ~w1c) | rise)) | (~edge_sel & irq_cur);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
            edge_sel <= '0;
        end else begin
            irq_prev <= irq_cur;
            pending  <= pending_nxt;
            if (i_we && (i_addr == REG_MASK)) begin
                mask <= i_wdata[NUM_IRQ-1:0];
            end
            if (i_we && (i_addr == REG_EDGE)) begin
                edge_sel <= i_wdata[NUM_IRQ-1:0];
            end
        end
    end

    assign req = pending & mask;

    mips_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req   (req),
        .valid (any_req),
        .idx   (win_idx)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state               <= IDLE;
            o_coproc0_interrupt <= 1'b0;
            o_cause             <= 4'd0;
        end else begin
            state               <= state_nxt;
            o_coproc0_interrupt <= intr_nxt;
            o_cause             <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        intr_nxt  = o_coproc0_interrupt;
        cause_nxt = o_cause;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = REQ;
                    intr_nxt  = 1'b1;
                    cause_nxt = win_idx;
                end
            end
            REQ: begin
                // Ack takes precedence over a request that vanishes in the same cycle.
                if (i_irq_ack) begin
                    state_nxt = SERVICE;
                    intr_nxt  = 1'b0;
                end else if (!any_req) begin
                    state_nxt = IDLE;
                    intr_nxt  = 1'b0;
                end
            end
            SERVICE: begin
                intr_nxt = 1'b0;
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                intr_nxt  = 1'b0;
            end
        endcase
    end

    // Reads see the registers as they stand before any same-cycle write.
    always_comb begin
        o_rdata = '0;
        if (i_re) begin
            case (i_addr)
                REG_PENDING: o_rdata[NUM_IRQ-1:0] = pending;
                REG_MASK:    o_rdata[NUM_IRQ-1:0] = mask;
                REG_EDGE:    o_rdata[NUM_IRQ-1:0] = edge_sel;
                REG_STATUS: begin
                    o_rdata[STAT_STATE_LSB +: 2]              = state;
                    o_rdata[STAT_ANY_BIT]                     = any_req;
                    o_rdata[STAT_CAUSE_LSB +: STAT_CAUSE_W]   = o_cause;
                end
                default: o_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_irq_ctrl.sv
// Self-checking bench for mips_irq_ctrl: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the register/FSM rules.
module tb_mips_irq_ctrl;

    localparam int N  = 8;
    localparam int DW = 32;
`ifdef MIPS_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq;
    logic          ack;
    logic [1:0]    addr;
    logic          we;
    logic          re;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          intr;
    logic [3:0]    cause;

    always #5 clk = ~clk;

    mips_irq_ctrl #(
        .NUM_IRQ (N),
        .DATA_W  (DW)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_irq               (irq),
        .i_irq_ack           (ack),
        .i_addr              (addr),
        .i_we                (we),
        .i_re                (re),
        .i_wdata             (wdata),
        .o_rdata             (rdata),
        .o_coproc0_interrupt (intr),
        .o_cause             (cause)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: state 0=idle, 1=requesting, 2=in service.
    logic [N-1:0] m_pend, m_mask, m_edge, m_prev, m_h0, m_h1;
    int           m_state;
    logic         m_out;
    logic [3:0]   m_cause;

    function automatic logic [DW-1:0] exp_rd(input logic [1:0] a);
        logic [DW-1:0] r;
        int            anyr;
        anyr = ((m_pend & m_mask) != 0) ? 1 : 0;
        r = '0;
        case (a)
            2'd0: r[N-1:0] = m_pend;
            2'd1: r[N-1:0] = m_mask;
            2'd2: r[N-1:0] = m_edge;
            default: r = DW'(m_state * 256 + anyr * 16 + int'(m_cause));
        endcase
        return r;
    endfunction

    // Advance the model and the DUT by one clock using the inputs currently driven.
    task automatic step();
        logic [N-1:0] cur, w1c, np, req;
        int           win, ns;
        logic         no;
        logic [3:0]   nc;
        cur = (LAT == 0) ? irq : m_h1;
        w1c = (we && addr == 2'd0) ? wdata[N-1:0] : '0;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) np[i] = (m_pend[i] && !w1c[i]) || (cur[i] && !m_prev[i]);
            else           np[i] = cur[i];
        end
        req = m_pend & m_mask;
        win = -1;
        for (int i = 0; i < N; i++) if (win < 0 && req[i]) win = i;
        ns = m_state; no = m_out; nc = m_cause;
        if (m_state == 0 && win >= 0) begin
            ns = 1; no = 1'b1; nc = 4'(win);
        end else if (m_state == 1 && ack) begin
            ns = 2; no = 1'b0;
        end else if (m_state == 1 && win < 0) begin
            ns = 0; no = 1'b0;
        end else if (m_state == 2 && we && addr == 2'd3) begin
            ns = 0;
        end
        @(posedge clk);
        if (!rst_n) begin
            m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0; m_h0 = '0; m_h1 = '0;
            m_state = 0; m_out = 1'b0; m_cause = 4'd0;
        end else begin
            if (we && addr == 2'd1) m_mask = wdata[N-1:0];
            if (we && addr == 2'd2) m_edge = wdata[N-1:0];
            m_pend = np; m_prev = cur; m_h1 = m_h0; m_h0 = irq;
            m_state = ns; m_out = no; m_cause = nc;
        end
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0; wdata = '0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        vectors++;
        if (intr !== 1'b0 || cause !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_out: intr=%b cause=%0d, want 0/0", intr, cause);
        end
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); re = 1'b1; #1;
            vectors++;
            if (rdata !== '0) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got %h want 0", a, rdata);
            end
        end
        re = 1'b0;
    endtask

    task automatic test_edge_latency();
        int lat;
        lat = -1;
        wr(2'd1, 32'h05);
        wr(2'd2, 32'h01);
        irq[0] = 1'b1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            step();
            if (intr === 1'b1) lat = k;
        end
        vectors++;
        if (lat != LAT + 2) begin
            miscompares++;
            $display("FAIL edge_latency: got %0d cycles want %0d", lat, LAT + 2);
        end
        vectors++;
        if (cause !== 4'd0 || intr !== m_out) begin
            miscompares++;
            $display("FAIL edge_cause: cause=%0d intr=%b want 0/%b", cause, intr, m_out);
        end
        addr = 2'd0; re = 1'b1; #1;
        vectors++;
        if (rdata !== 32'h01 || rdata !== exp_rd(2'd0)) begin
            miscompares++;
            $display("FAIL edge_pending: got %h want 01", rdata);
        end
        re = 1'b0;
        // Return to idle with nothing pending.
        do_ack();
        wr(2'd0, 32'h01);
        wr(2'd3, 32'h0);
        irq = '0;
        for (int k = 0; k < LAT + 2; k++) step();
    endtask

    task automatic test_priority();
        int k;
        irq[0] = 1'b1; irq[2] = 1'b1;
        k = 0;
        while (intr !== 1'b1 && k < 12) begin step(); k++; end
        vectors++;
        if (intr !== 1'b1 || cause !== 4'd0) begin
            miscompares++;
            $display("FAIL prio_first: intr=%b cause=%0d want 1/0", intr, cause);
        end
        do_ack();
        vectors++;
        if (intr !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_ack_drop: intr=%b want 0", intr);
        end
        wr(2'd0, 32'h01);
        wr(2'd3, 32'h0);
        addr = 2'd3; re = 1'b1; #1;
        vectors++;
        if (intr !== 1'b0 || rdata[9:8] !== 2'd0) begin
            miscompares++;
            $display("FAIL prio_idle_gap: intr=%b state=%0d want 0/0", intr, rdata[9:8]);
        end
        re = 1'b0;
        step();
        vectors++;
        if (intr !== 1'b1 || cause !== 4'd2 || cause !== m_cause) begin
            miscompares++;
            $display("FAIL prio_second: intr=%b cause=%0d want 1/2", intr, cause);
        end
    endtask

    task automatic test_mask_drop();
        wr(2'd1, 32'h0);
        step();
        addr = 2'd3; re = 1'b1; #1;
        vectors++;
        if (intr !== 1'b0 || rdata[9:8] !== 2'd0 || rdata !== exp_rd(2'd3)) begin
            miscompares++;
            $display("FAIL mask_drop: intr=%b status=%h want 0/state 0", intr, rdata);
        end
        re = 1'b0;
    endtask

    task automatic test_w1c_vs_set();
        irq = '0;
        wr(2'd2, 32'h01);
        for (int k = 0; k < LAT + 2; k++) step();
        irq[0] = 1'b1;
        for (int k = 0; k < LAT; k++) step();
        wr(2'd0, 32'h01);
        addr = 2'd0; re = 1'b1; #1;
        vectors++;
        if (rdata[0] !== 1'b1 || rdata !== exp_rd(2'd0)) begin
            miscompares++;
            $display("FAIL w1c_set_wins: pending=%h want bit0=1", rdata);
        end
        re = 1'b0;
        wr(2'd0, 32'h01);
        addr = 2'd0; re = 1'b1; #1;
        vectors++;
        if (rdata[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL w1c_clear: pending=%h want bit0=0", rdata);
        end
        re = 1'b0;
    endtask

    task automatic test_ignored();
        int k;
        do_ack();
        addr = 2'd3; re = 1'b1; #1;
        vectors++;
        if (intr !== 1'b0 || rdata[9:8] !== 2'd0) begin
            miscompares++;
            $display("FAIL ack_in_idle: intr=%b state=%0d want 0/0", intr, rdata[9:8]);
        end
        re = 1'b0;
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h01);
        k = 0;
        while (intr !== 1'b1 && k < 12) begin step(); k++; end
        wr(2'd3, 32'h0);
        addr = 2'd3; re = 1'b1; #1;
        vectors++;
        if (intr !== 1'b1 || rdata[9:8] !== 2'd1) begin
            miscompares++;
            $display("FAIL eoi_in_req: intr=%b state=%0d want 1/1", intr, rdata[9:8]);
        end
        re = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        irq = 8'hFF;
        wr(2'd1, 32'hFF);
        for (int k = 0; k < LAT + 2; k++) step();
        addr = 2'd0; re = 1'b1; #1;
        vectors++;
        if (rdata !== 32'hFF || intr !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: pending=%h intr=%b want ff/1", rdata, intr);
        end
        re = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if (intr !== 1'b0 || cause !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_req: intr=%b cause=%0d want 0/0", intr, cause);
        end
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); re = 1'b1; #1;
            vectors++;
            if (rdata !== '0) begin
                miscompares++;
                $display("FAIL reset_mid_reg%0d: got %h want 0", a, rdata);
            end
        end
        re = 1'b0;
        irq = '0;
        for (int k = 0; k < LAT + 2; k++) step();
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        for (int c = 0; c < 600; c++) begin
            irq   = N'($urandom);
            ack   = ($urandom_range(0, 3) == 0);
            we    = ($urandom_range(0, 2) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            re    = 1'b1;
            #1;
            e = exp_rd(addr);
            vectors++;
            if (rdata !== e) begin
                miscompares++;
                $display("FAIL rand_rd c=%0d a=%0d: got %h want %h", c, addr, rdata, e);
            end
            step();
            vectors++;
            if (intr !== m_out || cause !== m_cause) begin
                miscompares++;
                $display("FAIL rand_out c=%0d: intr=%b cause=%0d want %b/%0d", c, intr, cause, m_out, m_cause);
            end
        end
        ack = 1'b0; we = 1'b0; re = 1'b0; wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; irq = '0; ack = 1'b0; addr = 2'd0; we = 1'b0; re = 1'b0; wdata = '0;
        m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0; m_h0 = '0; m_h1 = '0;
        m_state = 0; m_out = 1'b0; m_cause = 4'd0;
        #1;
        test_reset();
        test_edge_latency();
        test_priority();
        test_mask_drop();
        test_w1c_vs_set();
        test_ignored();
        test_reset_mid_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
